// File: rtl/serial_compare_ctrl.sv
// -----------------------------------------------------------------------------
// serial_compare_ctrl
//
// Compares two WIDTH-bit unsigned operands using one shared 2-bit magnitude
// comparator slice, walking the operands MSB pair first at two bits per clock.
// The walk stops on the first unequal pair, so latency is 1..WIDTH/2 cycles.
//
// Ports
//   clk    in   1      rising-edge clock
//   rst_n  in   1      asynchronous active-low reset
//   start  in   1      compare request, sampled only while idle
//   a_in   in   WIDTH  operand A, captured on the accepting edge
//   b_in   in   WIDTH  operand B, captured on the accepting edge
//   busy   out  1      compare in progress
//   done   out  1      one-cycle pulse, eq/lt/gt were just updated
//   eq     out  1      A == B for the last completed compare
//   lt     out  1      A <  B for the last completed compare
//   gt     out  1      A >  B for the last completed compare
// -----------------------------------------------------------------------------

// 2-bit unsigned magnitude comparator slice.
module two_bit_comparator (
  input  logic [1:0] a,
  input  logic [1:0] b,
  output logic       eq,
  output logic       lt,
  output logic       gt
);

  assign eq = (a == b);
  assign lt = (a <  b);
  assign gt = (a >  b);

endmodule

module serial_compare_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  output logic             busy,
  output logic             done,
  output logic             eq,
  output logic             lt,
  output logic             gt
);

  localparam int STEPS = WIDTH / 2;
  localparam int CNT_W = (STEPS > 1) ? $clog2(STEPS) : 1;

  typedef enum logic {
    IDLE,
    CMP
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] sa;
  logic [WIDTH-1:0] sb;
  logic [CNT_W-1:0] cnt;

  logic slice_eq;
  logic slice_lt;
  logic slice_gt;

  // The slice always looks at the current top pair; shifting the operands
  // left brings the next pair into view.
  two_bit_comparator u_slice (
    .a  (sa[WIDTH-1 -: 2]),
    .b  (sb[WIDTH-1 -: 2]),
    .eq (slice_eq),
    .lt (slice_lt),
    .gt (slice_gt)
  );

  // NOTE: every register, including the operand shift registers, is cleared
  // by reset so a mid-compare reset leaves no stale state behind; the
  // updates below use non-blocking assignments so all registers sample the
  // same pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      sa    <= '0;
      sb    <= '0;
      cnt   <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
      eq    <= 1'b0;
      lt    <= 1'b0;
      gt    <= 1'b0;
    end else begin
      // done is a single-cycle pulse unless a completion re-asserts it.
      done <= 1'b0;

      case (state)
        IDLE: begin
          if (start) begin
            sa    <= a_in;
            sb    <= b_in;
            cnt   <= CNT_W'(STEPS - 1);
            busy  <= 1'b1;
            state <= CMP;
          end
        end

        CMP: begin
          if (!slice_eq) begin
            // First unequal pair decides the whole compare.
            eq    <= 1'b0;
            lt    <= slice_lt;
            gt    <= slice_gt;
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= IDLE;
          end else if (cnt == '0) begin
            // Last pair equal and every earlier pair equal.
            eq    <= 1'b1;
            lt    <= 1'b0;
            gt    <= 1'b0;
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= IDLE;
          end else begin
            sa  <= sa << 2;
            sb  <= sb << 2;
            cnt <= cnt - 1'b1;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_compare_ctrl.sv
module tb_serial_compare_ctrl;

  typedef struct {
    logic eq;
    logic lt;
    logic gt;
    int   lat;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;

  logic       start8 = 1'b0;
  logic [7:0] a8 = '0;
  logic [7:0] b8 = '0;
  logic       busy8, done8, eq8, lt8, gt8;

  logic       start2 = 1'b0;
  logic [1:0] a2 = '0;
  logic [1:0] b2 = '0;
  logic       busy2, done2, eq2, lt2, gt2;

  exp_t q8[$];
  exp_t q2[$];

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  serial_compare_ctrl #(.WIDTH(8)) dut8 (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start8),
    .a_in  (a8),
    .b_in  (b8),
    .busy  (busy8),
    .done  (done8),
    .eq    (eq8),
    .lt    (lt8),
    .gt    (gt8)
  );

  serial_compare_ctrl #(.WIDTH(2)) dut2 (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start2),
    .a_in  (a2),
    .b_in  (b2),
    .busy  (busy2),
    .done  (done2),
    .eq    (eq2),
    .lt    (lt2),
    .gt    (gt2)
  );

  // Reference model for 8-bit: result flags plus cycles from accept to done.
  function automatic exp_t model8(input logic [7:0] a, input logic [7:0] b);
    exp_t e;
    e.eq  = (a == b);
    e.lt  = (a < b);
    e.gt  = (a > b);
    e.lat = 4;
    for (int j = 0; j < 4; j++) begin
      if (a[7-2*j -: 2] != b[7-2*j -: 2]) begin
        e.lat = j + 1;
        break;
      end
    end
    return e;
  endfunction

  // Drives one 8-bit compare from an idle DUT and scores the result.
  // Called #1 after a rising edge.
  task automatic compare8(input logic [7:0] a, input logic [7:0] b, input string name);
    exp_t e;
    int   n;
    q8.push_back(model8(a, b));
    a8 = a;
    b8 = b;
    start8 = 1'b1;
    @(posedge clk); #1;
    start8 = 1'b0;
    checks++;
    if (busy8 !== 1'b1 || done8 !== 1'b0) begin
      failures++;
      $display("FAIL %s_accept: busy=%b done=%b, required busy=1 done=0", name, busy8, done8);
    end
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (done8 !== 1'b1 && n < 20);
    e = q8.pop_front();
    checks++;
    if (done8 !== 1'b1 || n != e.lat) begin
      failures++;
      $display("FAIL %s_latency: done=%b after %0d edges, required done=1 after %0d", name, done8, n, e.lat);
    end
    checks++;
    if ({eq8, lt8, gt8, busy8} !== {e.eq, e.lt, e.gt, 1'b0}) begin
      failures++;
      $display("FAIL %s_result: eq/lt/gt/busy=%b%b%b%b, required %b%b%b0", name, eq8, lt8, gt8, busy8,
               e.eq, e.lt, e.gt);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({busy8, done8, eq8, lt8, gt8, busy2, done2, eq2, lt2, gt2} !== 10'b0) begin
      failures++;
      $display("FAIL reset_outputs: w8=%b%b%b%b%b w2=%b%b%b%b%b, required all 0",
               busy8, done8, eq8, lt8, gt8, busy2, done2, eq2, lt2, gt2);
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
    checks++;
    if ({busy8, done8, eq8, lt8, gt8} !== 5'b0) begin
      failures++;
      $display("FAIL idle_no_start: busy/done/eq/lt/gt=%b%b%b%b%b, required 00000", busy8, done8, eq8, lt8, gt8);
    end
  endtask

  task automatic test_equal();
    compare8(8'hA5, 8'hA5, "equal_a5");
  endtask

  task automatic test_early_exit();
    compare8(8'h80, 8'h7F, "msb_gt");
  endtask

  task automatic test_lsb_diff_and_hold();
    compare8(8'h12, 8'h13, "lsb_lt");
    a8 = 8'hFF;
    b8 = 8'h00;
    repeat (3) begin
      @(posedge clk); #1;
      checks++;
      if ({busy8, done8, eq8, lt8, gt8} !== 5'b00010) begin
        failures++;
        $display("FAIL hold_result: busy/done/eq/lt/gt=%b%b%b%b%b, required 00010", busy8, done8, eq8, lt8, gt8);
      end
    end
  endtask

  task automatic test_back_to_back();
    exp_t e;
    int   n;
    q8.push_back(model8(8'h12, 8'h13));
    a8 = 8'h12;
    b8 = 8'h13;
    start8 = 1'b1;
    @(posedge clk); #1;
    start8 = 1'b0;
    n = 0;
    // Request and operand change while busy: must be ignored.
    @(posedge clk); #1;
    n++;
    a8 = 8'h00;
    b8 = 8'hFF;
    start8 = 1'b1;
    @(posedge clk); #1;
    n++;
    start8 = 1'b0;
    while (done8 !== 1'b1 && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    e = q8.pop_front();
    checks++;
    if (done8 !== 1'b1 || n != e.lat || {eq8, lt8, gt8} !== {e.eq, e.lt, e.gt}) begin
      failures++;
      $display("FAIL busy_start_ignored: done=%b edges=%0d eq/lt/gt=%b%b%b, required done=1 edges=%0d %b%b%b",
               done8, n, eq8, lt8, gt8, e.lat, e.eq, e.lt, e.gt);
    end
    // Start in the done cycle is accepted on the next edge.
    q8.push_back(model8(8'h40, 8'h00));
    a8 = 8'h40;
    b8 = 8'h00;
    start8 = 1'b1;
    @(posedge clk); #1;
    start8 = 1'b0;
    checks++;
    if ({busy8, done8, eq8, lt8, gt8} !== 5'b10010) begin
      failures++;
      $display("FAIL b2b_accept: busy/done/eq/lt/gt=%b%b%b%b%b, required 10010", busy8, done8, eq8, lt8, gt8);
    end
    @(posedge clk); #1;
    e = q8.pop_front();
    checks++;
    if ({busy8, done8, eq8, lt8, gt8} !== {1'b0, 1'b1, e.eq, e.lt, e.gt}) begin
      failures++;
      $display("FAIL b2b_result: busy/done/eq/lt/gt=%b%b%b%b%b, required 01%b%b%b", busy8, done8, eq8, lt8, gt8,
               e.eq, e.lt, e.gt);
    end
  endtask

  task automatic test_mid_reset();
    a8 = 8'hA5;
    b8 = 8'hA5;
    start8 = 1'b1;
    @(posedge clk); #1;
    start8 = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({busy8, done8, eq8, lt8, gt8} !== 5'b0) begin
      failures++;
      $display("FAIL async_reset: busy/done/eq/lt/gt=%b%b%b%b%b, required 00000", busy8, done8, eq8, lt8, gt8);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (4) begin
      @(posedge clk); #1;
      checks++;
      if (done8 !== 1'b0 || busy8 !== 1'b0) begin
        failures++;
        $display("FAIL no_done_after_abort: done=%b busy=%b, required 0 0", done8, busy8);
      end
    end
    compare8(8'h80, 8'h7F, "post_reset");
  endtask

  task automatic test_width2();
    exp_t e;
    e.lat = 1;
    // start stays high for all 16 pairs; each new pair is presented in the
    // done cycle of the previous one.
    a2 = 2'd0;
    b2 = 2'd0;
    e.eq = 1'b1; e.lt = 1'b0; e.gt = 1'b0;
    q2.push_back(e);
    start2 = 1'b1;
    for (int i = 0; i < 16; i++) begin
      @(posedge clk); #1;
      checks++;
      if (busy2 !== 1'b1 || done2 !== 1'b0) begin
        failures++;
        $display("FAIL w2_accept_%0d: busy=%b done=%b, required 1 0", i, busy2, done2);
      end
      @(posedge clk); #1;
      e = q2.pop_front();
      checks++;
      if ({busy2, done2, eq2, lt2, gt2} !== {1'b0, 1'b1, e.eq, e.lt, e.gt}) begin
        failures++;
        $display("FAIL w2_pair_%0d: busy/done/eq/lt/gt=%b%b%b%b%b, required 01%b%b%b", i, busy2, done2,
                 eq2, lt2, gt2, e.eq, e.lt, e.gt);
      end
      checks++;
      if (($countones({eq2, lt2, gt2}) != 1)) begin
        failures++;
        $display("FAIL w2_onehot_%0d: eq/lt/gt=%b%b%b, required exactly one high", i, eq2, lt2, gt2);
      end
      if (i < 15) begin
        a2 = 2'((i + 1) / 4);
        b2 = 2'((i + 1) % 4);
        e.eq = (a2 == b2);
        e.lt = (a2 < b2);
        e.gt = (a2 > b2);
        q2.push_back(e);
      end else begin
        start2 = 1'b0;
      end
    end
    @(posedge clk); #1;
    checks++;
    if (busy2 !== 1'b0 || done2 !== 1'b0 || q2.size() != 0) begin
      failures++;
      $display("FAIL w2_drain: busy=%b done=%b pending=%0d, required 0 0 0", busy2, done2, q2.size());
    end
  endtask

  initial begin
    test_reset();
    test_equal();
    test_early_exit();
    test_lsb_diff_and_hold();
    test_back_to_back();
    test_mid_reset();
    test_width2();
    checks++;
    if (q8.size() != 0) begin
      failures++;
      $display("FAIL w8_drain: pending=%0d, required 0", q8.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Independent watchdog so the run always terminates.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

endmodule
